mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator-side load/store controller that drives the single-port word-organised data memory (combinational read, write on posedge when write-enable is high).
- Sits between the CPU datapath and the data memory.
- Turns byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses, using read-modify-write for sub-word stores.
- Reports misalignment instead of touching memory.

Parameters:
- ADDR_W, 32, width of CPU byte address.
- MEM_IDX_W, 6, memory word-index width; memory holds 2^MEM_IDX_W words.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned.
- req_unsigned  in  1  zero-extend loads (ignored for stores and word size).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; byte in [7:0], half in [15:0].
- resp_valid  out  1  one-cycle pulse, completion.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal size; valid with resp_valid.
- mem_we  out  1  to data memory write enable.
- mem_addr  out  32  word index {zeros, req_addr[MEM_IDX_W+1:2]}.
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- Reset: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0. All internal latches cleared.
- Reset mid-operation aborts the operation. No mem_we is issued in the cycle after rst is sampled high.
- Byte lanes are little-endian: byte k of a word occupies bits [8k+7:8k]; k = addr[1:0]. Half lane = addr[1].
- Misaligned: half with addr[0] = 1; word with addr[1:0] != 0; size 11.
- Accept: in IDLE, when req_valid = 1, latch store, size, unsigned, addr and wdata; req_ready drops the next cycle.
- IDLE:
  - Misaligned request -> RESP with err = 1.
  - Otherwise -> ACCESS.
- ACCESS:
  - mem_addr driven from the latched address.
  - Load: extract lane from mem_rdata and sign/zero-extend into the result register -> RESP.
  - SW: mem_we = 1, mem_wdata = latched wdata -> RESP.
  - SB/SH: latch mem_rdata into the merge register, mem_we = 0 -> WRITE.
- WRITE:
  - mem_we = 1.
  - mem_wdata = merge word with the target lane replaced by wdata[7:0] or [15:0]; other lanes preserved bit-exact.
  - -> RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle; resp_rdata and resp_err valid.
  - -> IDLE; req_ready = 1 the following cycle.
- Latency, counted as cycles from the accept edge to the resp_valid cycle: load 2, SW 2, SB/SH 3, misaligned 1.
- mem_we is never asserted in IDLE or RESP, and is asserted at most once per request.
- resp_rdata holds its value until the next response; it is cleared to 0 on store or error responses.
- Address bits above MEM_IDX_W+1 are ignored, so addresses wrap modulo 2^(MEM_IDX_W+2) bytes.

Optional Feature:
- Macro: MEM_ACCESS_STATS_EN.
- When defined, adds three output ports, each 32 bits, cleared by rst:
  - stat_loads: counts completed non-error loads.
  - stat_stores: counts completed non-error stores.
  - stat_errs: counts error responses.
- Each counter increments in the RESP cycle and wraps at 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then SW addr 0x08 data 0xDEADBEEF -> mem_we for one cycle with mem_addr = 2, mem_wdata = 0xDEADBEEF; resp_valid 2 cycles after accept, resp_err = 0.
- LB addr 0x0B after the above -> resp_rdata = 0xFFFFFFDE. LBU addr 0x0B -> 0x000000DE. LH addr 0x08 -> 0xFFFFBEEF. LHU addr 0x0A -> 0x0000DEAD.
- SB addr 0x09 data 0x12 -> read cycle with mem_we = 0, then write cycle with mem_wdata = 0xDEAD12EF; resp_valid 3 cycles after accept. A following LW 0x08 returns 0xDEAD12EF.
- LH addr 0x05, SW addr 0x06, size 11 -> resp_valid 1 cycle after accept, resp_err = 1, mem_we never asserted, memory unchanged.
- Assert rst during the WRITE-pending cycle of SH addr 0x0C -> no mem_we; outputs at reset values; next request is accepted normally.
- Address wrap: SW addr 0x100 with MEM_IDX_W = 6 -> mem_addr = 0. With MEM_ACCESS_STATS_EN defined, after the above sequence the counters equal the expected load, store and error totals.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store controller between the CPU datapath and a
// single-port, word-organised data memory (combinational read, posedge write).
// Byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests become word accesses;
// sub-word stores use read-modify-write; misaligned or illegal-size requests
// are answered with resp_err and never reach memory.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_*           request handshake and payload (accepted in IDLE only)
//   resp_*          one-cycle completion pulse with load data / error flag
//   mem_*           data memory interface (word index, write enable, data)
//
// Optional build macro MEM_ACCESS_STATS_EN adds stat_loads, stat_stores and
// stat_errs completion counters (32 bit, wrapping).
module mem_access_unit #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_IDX_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [31:0]       stat_loads,
    output logic [31:0]       stat_stores,
    output logic [31:0]       stat_errs
`endif
);

    // Byte-address bits that actually select a location; higher bits wrap.
    localparam int unsigned BA_W = MEM_IDX_W + 2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              store_q, store_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [BA_W-1:0]   addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;

    logic              req_ready_d;
    logic              resp_valid_d;
    logic [31:0]       resp_rdata_d;
    logic              resp_err_d;
    logic              mem_we_d;
    logic [31:0]       mem_wdata_d;

    logic              misalign_c;
    logic [7:0]        lane_b_c;
    logic [15:0]       lane_h_c;
    logic [31:0]       load_c;
    logic [31:0]       merge_c;

    // Upper address bits are intentionally ignored (address wrap).
    logic              unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:BA_W];

    // Word index comes straight from the latched address register.
    assign mem_addr = 32'(addr_q[BA_W-1:2]);

    // Alignment / legality check on the incoming request.
    always_comb begin
        misalign_c = 1'b0;
        case (req_size)
            SZ_B:    misalign_c = 1'b0;
            SZ_H:    misalign_c = req_addr[0];
            SZ_W:    misalign_c = |req_addr[1:0];
            default: misalign_c = 1'b1;
        endcase
    end

    // Lane extraction and sign/zero extension for loads.
    always_comb begin
        lane_b_c = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h_c = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_B:    load_c = unsigned_q ? {24'd0, lane_b_c} : {{24{lane_b_c[7]}}, lane_b_c};
            SZ_H:    load_c = unsigned_q ? {16'd0, lane_h_c} : {{16{lane_h_c[15]}}, lane_h_c};
            default: load_c = mem_rdata;
        endcase
    end

    // Read-modify-write merge: replace only the target lane of the read word.
    always_comb begin
        merge_c = mem_rdata;
        if (size_q == SZ_B) begin
            merge_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merge_c[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    // Next-state and next-output logic; outputs are registered from *_d.
    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata;
        resp_err_d   = 1'b0;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    store_d    = req_store;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr[BA_W-1:0];
                    wdata_d    = req_wdata[15:0];
                    if (misalign_c) begin
                        state_d      = S_RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else begin
                        state_d = S_ACCESS;
                        // Full-word store writes during the ACCESS cycle.
                        if (req_store && req_size == SZ_W) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = req_wdata;
                        end
                    end
                end
            end
            S_ACCESS: begin
                if (!store_q) begin
                    resp_rdata_d = load_c;
                    state_d      = S_RESP;
                end else if (size_q == SZ_W) begin
                    resp_rdata_d = 32'd0;
                    state_d      = S_RESP;
                end else begin
                    // mem_wdata doubles as the merge register for the WRITE cycle.
                    mem_wdata_d = merge_c;
                    mem_we_d    = 1'b1;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                resp_rdata_d = 32'd0;
                state_d      = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        resp_valid_d = (state_d == S_RESP);
        req_ready_d  = (state_d == S_IDLE);
    end

    // State, request latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            store_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 16'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= 32'd0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
            mem_we     <= mem_we_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    // Completion counters, bumped once in each RESP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_loads  <= 32'd0;
            stat_stores <= 32'd0;
            stat_errs   <= 32'd0;
        end else if (state_q == S_RESP) begin
            if (resp_err) begin
                stat_errs <= stat_errs + 32'd1;
            end else if (store_q) begin
                stat_stores <= stat_stores + 32'd1;
            end else begin
                stat_loads <= stat_loads + 32'd1;
            end
        end
    end
`endif

endmodule
